burst_responder: RTL
====================

BURST_RESPONDER -- requirements
Module: burst_responder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- addr_width, 32, byte address width.
- data_width, 32, beat width; a multiple of 8; BPB = data_width/8.
- mem_depth, 1024, SRAM words; a power of 2.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), with clock and reset first:
- clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- wr_req, in, 1; wr_gnt, out, 1; wr_len, in, 16 (bytes); wr_addr, in, addr_width.
- wr_data, in, data_width; wr_valid, in, 1; wr_last, in, 1; wr_ready, out, 1; wr_done, out, 1.
- rd_req, in, 1; rd_gnt, out, 1; rd_len, in, 16; rd_addr, in, addr_width.
- rd_data, out, data_width; rd_valid, out, 1; rd_ready, in, 1; rd_done, out, 1.
- sram_en, out, 1; sram_we, out, 1; sram_addr, out, $clog2(mem_depth); sram_wdata, out, data_width.
- sram_rdata, in, data_width; sram_rdata is valid in the cycle after sram_en && !sram_we.

Function
REQ-003 The block SHALL serve exactly one burst at a time, using FSM states IDLE, WR_DATA, WR_RESP, RD_DATA.
REQ-004 In IDLE, the grants SHALL be: wr_gnt = wr_req; rd_gnt = rd_req && !wr_req. When both requests are present, the write wins; grants are 0 in every other state.
REQ-005 On a grant, the block SHALL latch the following and go to WR_DATA or RD_DATA:
- base = addr >> log2(BPB);
- beats = ceil(len/BPB), with len 0 treated as 1 beat.
REQ-006 Beat k of a burst SHALL address SRAM word (base+k) mod mem_depth, wrapping silently.
REQ-007 In WR_DATA:
- wr_ready SHALL be 1.
- Each wr_valid && wr_ready beat SHALL drive sram_en=1, sram_we=1, sram_addr=beat address and sram_wdata=wr_data in the same cycle.
REQ-008 WR_DATA SHALL exit to WR_RESP on whichever comes first: the handshake with wr_last=1, or the handshake of beat number beats. Any later wr_valid is not accepted.
REQ-009 wr_done SHALL pulse for exactly the one WR_RESP cycle, which is the cycle after the final beat; the FSM then returns to IDLE.
REQ-010 In RD_DATA, the block SHALL issue an SRAM read (sram_en=1, sram_we=0) when both hold:
- issued < beats;
- fifo_count + inflight − pop < 2.
Returned data SHALL be pushed into a 2-entry output FIFO.
REQ-011 rd_valid SHALL equal FIFO not-empty, and rd_data SHALL equal the FIFO head.
REQ-012 rd_done SHALL equal rd_valid && (head beat index == beats−1); the FSM returns to IDLE in the cycle after that beat's rd_valid && rd_ready.
REQ-013 Read latency SHALL be as follows:
- the grant is in cycle C0 and the first sram read in C1;
- the first rd_valid is in C3;
- with rd_ready held at 1, the beats SHALL follow back to back, one per cycle.
REQ-014 Under any rd_ready pattern, no beat SHALL be lost or duplicated, and at most 2 beats SHALL be outstanding (inflight plus FIFO).
REQ-015 sram_en SHALL be 0 in IDLE and in WR_RESP.

Reset
REQ-016 While rst_n = 0, the block SHALL be in IDLE, with counters and FIFO emptied and all outputs 0.
REQ-017 Reset asserted mid-burst SHALL abandon the burst: no wr_done or rd_done follows, and the next request after release is served normally.

Configuration
REQ-018 With BURST_RESPONDER_ERR_EN defined, the block SHALL add the output port resp_err (1 bit, sticky until reset). resp_err SHALL set when:
- wr_last arrives before beat number beats; or
- beat number beats is accepted with wr_last=0; or
- a burst wraps past mem_depth.
REQ-019 Without BURST_RESPONDER_ERR_EN, the resp_err port SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-020 Package burst_responder_pkg SHALL hold:
- the state enum;
- a beats-from-length function.
REQ-021 The 2-entry output FIFO SHALL be a sub-module named burst_responder_fifo, with push/pop/full/empty/count ports.

Verification
REQ-022 Write burst: wr_addr=0x100, wr_len=128, 32 beats, wr_last on beat 32.
- Expect SRAM writes to words 0x40..0x5F.
- Expect a single wr_done one cycle after the last beat.
REQ-023 Read burst: rd_addr=0x100, rd_len=128, rd_ready=1.
- Expect the grant at C0 and rd_valid from C3 for 32 consecutive cycles.
- Expect the data to match REQ-022, with rd_done only on beat 32.
REQ-024 Simultaneous requests: wr_req and rd_req raised together.
- Expect wr_gnt first.
- Expect rd_gnt in the cycle after the wr_done cycle.
REQ-025 Backpressure: read of 8 beats, with rd_ready toggling in a random pattern.
- Expect all 8 beats in order, with no loss or duplication.
- Expect at most 2 outstanding beats at any time.
REQ-026 Wrap and reset:
- mem_depth=1024, rd_addr=0xFF8, rd_len=16: expect word addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Reset asserted at beat 2 of a write: expect no wr_done, and the next burst to complete.
REQ-027 With BURST_RESPONDER_ERR_EN defined:
- a 4-beat write with wr_last on beat 2 gives resp_err=1, exactly 2 SRAM writes, and wr_done;
- a clean burst leaves resp_err=0.

Source files
------------

// File: rtl/burst_responder_pkg.sv
// rtl/burst_responder_pkg.sv - shared FSM state type and burst length helper
// Contents: state_t (IDLE, WR_DATA, WR_RESP, RD_DATA), beats_from_len().
package burst_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    // Number of beats covering len bytes; a zero length still moves one beat.
    function automatic logic [16:0] beats_from_len(input logic [15:0] len, input int unsigned bpb);
        logic [16:0] l;
        l = {1'b0, len};
        if (len == 16'd0) begin
            return 17'd1;
        end
        return (l + 17'(bpb) - 17'd1) / 17'(bpb);
    endfunction

endpackage

// File: rtl/burst_responder_fifo.sv
// rtl/burst_responder_fifo.sv - two-entry output FIFO for read return data
// Ports: clk, rst_n (async active-low), push/push_data, pop, head (oldest entry),
//        full, empty, count (0..2). Push when full and pop when empty are ignored.
module burst_responder_fifo #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [width-1:0] mem0;
    logic [width-1:0] mem1;
    logic             wptr;
    logic             rptr;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != 2'd2);
    assign do_pop  = pop && (cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0 <= '0;
            mem1 <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wptr) begin
                    mem1 <= push_data;
                end else begin
                    mem0 <= push_data;
                end
                wptr <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head  = rptr ? mem1 : mem0;
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;

endmodule

// File: rtl/burst_responder.sv
// rtl/burst_responder.sv - single-burst SRAM write/read responder
// Ports: clk, rst_n (async active-low); write request wr_req/wr_gnt/wr_len/wr_addr,
//        write stream wr_data/wr_valid/wr_last/wr_ready, completion wr_done;
//        read request rd_req/rd_gnt/rd_len/rd_addr, read stream rd_data/rd_valid/rd_ready,
//        completion rd_done; SRAM sram_en/sram_we/sram_addr/sram_wdata, sram_rdata
//        (one-cycle read latency). Option macro BURST_RESPONDER_ERR_EN adds sticky resp_err.
module burst_responder
    import burst_responder_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int mem_depth  = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_req,
    output logic                         wr_gnt,
    input  logic [15:0]                  wr_len,
    input  logic [addr_width-1:0]        wr_addr,
    input  logic [data_width-1:0]        wr_data,
    input  logic                         wr_valid,
    input  logic                         wr_last,
    output logic                         wr_ready,
    output logic                         wr_done,
    input  logic                         rd_req,
    output logic                         rd_gnt,
    input  logic [15:0]                  rd_len,
    input  logic [addr_width-1:0]        rd_addr,
    output logic [data_width-1:0]        rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic                         rd_done,
    output logic                         sram_en,
    output logic                         sram_we,
    output logic [$clog2(mem_depth)-1:0] sram_addr,
    output logic [data_width-1:0]        sram_wdata,
`ifdef BURST_RESPONDER_ERR_EN
    output logic                         resp_err,
`endif
    input  logic [data_width-1:0]        sram_rdata
);

    localparam int bpb  = data_width / 8;
    localparam int saw  = $clog2(mem_depth);
    localparam int boff = $clog2(bpb);

    state_t          state;
    logic [16:0]     beats;
    logic [16:0]     cnt;      // beats accepted (write) or popped (read)
    logic [16:0]     issued;   // SRAM reads issued
    logic [16:0]     cnt_inc;
    logic [saw-1:0]  base;
    logic            inflight; // a read was issued last cycle; its data is on sram_rdata now

    logic [addr_width-1:0] req_addr;
    logic [addr_width-1:0] req_shifted;
    logic [15:0]           req_len;
    logic [16:0]           req_beats;
    logic                  wr_hs;
    logic                  wr_final;
    logic                  rd_issue;
    logic                  rd_pop;
    logic [2:0]            occ;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic                  unused_ok;

    // Grants are forced low while reset is held so every output reads 0.
    assign wr_gnt = rst_n && (state == IDLE) && wr_req;
    assign rd_gnt = rst_n && (state == IDLE) && rd_req && !wr_req;

    assign req_addr    = wr_gnt ? wr_addr : rd_addr;
    assign req_len     = wr_gnt ? wr_len : rd_len;
    assign req_shifted = req_addr >> boff;
    assign req_beats   = beats_from_len(req_len, bpb);

    assign cnt_inc  = cnt + 17'd1;
    assign wr_ready = (state == WR_DATA);
    assign wr_done  = (state == WR_RESP);
    assign wr_hs    = wr_ready && wr_valid;
    assign wr_final = wr_hs && (wr_last || (cnt_inc == beats));

    // Occupancy after this cycle's pop: FIFO entries plus the read whose data is returning.
    assign rd_pop   = rd_valid && rd_ready;
    assign occ      = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, rd_pop};
    assign rd_issue = (state == RD_DATA) && (issued < beats) && (occ < 3'd2);
    assign rd_valid = !fifo_empty;
    assign rd_done  = rd_valid && (cnt == beats - 17'd1);

    // Word addresses wrap modulo mem_depth through truncation.
    always_comb begin
        sram_en    = wr_hs || rd_issue;
        sram_we    = wr_hs;
        sram_addr  = '0;
        sram_wdata = '0;
        if (wr_hs) begin
            sram_addr  = base + cnt[saw-1:0];
            sram_wdata = wr_data;
        end else if (rd_issue) begin
            sram_addr = base + issued[saw-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beats    <= 17'd0;
            cnt      <= 17'd0;
            issued   <= 17'd0;
            base     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_issue;
            case (state)
                IDLE: begin
                    if (wr_gnt || rd_gnt) begin
                        base   <= req_shifted[saw-1:0];
                        beats  <= req_beats;
                        cnt    <= 17'd0;
                        issued <= 17'd0;
                        state  <= wr_gnt ? WR_DATA : RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (wr_hs) begin
                        cnt <= cnt_inc;
                        if (wr_final) begin
                            state <= WR_RESP;
                        end
                    end
                end
                WR_RESP: state <= IDLE;
                RD_DATA: begin
                    if (rd_issue) begin
                        issued <= issued + 17'd1;
                    end
                    if (rd_pop) begin
                        cnt <= cnt_inc;
                        if (rd_done) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    burst_responder_fifo #(
        .width(data_width)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_data(sram_rdata),
        .pop      (rd_pop),
        .head     (rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

`ifdef BURST_RESPONDER_ERR_EN
    logic [31:0] last_word;
    logic        wrap;

    assign last_word = 32'(req_shifted[saw-1:0]) + 32'(req_beats) - 32'd1;
    assign wrap      = last_word >= 32'(mem_depth);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err <= 1'b0;
        end else if (((wr_gnt || rd_gnt) && wrap) ||
                     (wr_hs && wr_last && (cnt_inc < beats)) ||
                     (wr_hs && !wr_last && (cnt_inc == beats))) begin
            resp_err <= 1'b1;
        end
    end
`endif

    assign unused_ok = ^{req_shifted[addr_width-1:saw], fifo_full};

endmodule
